// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the frame-buffer bypass write arbiter.
package fb_write_arbiter_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;

  // Requester index assignments on the shared bypass port
  localparam logic [IDX_W-1:0] REQ_CPU  = 3'd0;
  localparam logic [IDX_W-1:0] REQ_LINE = 3'd1;
  localparam logic [IDX_W-1:0] REQ_FILL = 3'd2;

  typedef enum logic {
    FBA_IDLE = 1'b0,
    FBA_LOCK = 1'b1
  } fba_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [WE_W-1:0]   we;
  } fb_beat_t;

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N_REQ.
module fb_write_arbiter_rr_pick
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [7:0]     req_ext;
  logic [IDX_W:0] pos;

  assign req_ext = 8'(req);

  // Rotate-and-priority-encode starting from ptr
  always_comb begin
    idx = ptr;
    any = 1'b0;
    pos = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      if (!any && req_ext[pos[IDX_W-1:0]]) begin
        idx = pos[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locking arbiter for the frame-buffer bypass write port.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 8,
  parameter bit          CPU_PRIO  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_din,
  input  logic [N_REQ*WE_W-1:0]   req_we,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fb_valid,
  input  logic                    fb_ready,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [DATA_W-1:0]       fb_din,
  output logic [WE_W-1:0]         fb_we,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);

  localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  fba_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [IDX_W-1:0]  grant_id_d;

  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  next_ptr;
  logic              grant_valid;
  logic              out_free;
  logic              accept;
  fb_beat_t          sel_beat;
  logic              sel_valid;
  logic              sel_last;
  fb_beat_t          fb_q;
  logic              addr_unused;

  fb_write_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (rr_idx),
    .any (rr_any)
  );

  // CPU only jumps the queue when no burst holds the port
  assign grant = (state_q == FBA_LOCK)          ? grant_id :
                 (CPU_PRIO && req_valid[0])     ? REQ_CPU  : rr_idx;

  assign next_ptr = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);

  // Route the granted requester's beat
  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_beat.addr = req_addr[ADDR_W*i +: ADDR_W];
        sel_beat.din  = req_din[DATA_W*i +: DATA_W];
        sel_beat.we   = req_we[WE_W*i +: WE_W];
        sel_valid     = req_valid[i];
        sel_last      = req_last[i];
      end
    end
  end

  assign grant_valid = (state_q == FBA_IDLE) ? rr_any : sel_valid;
  assign out_free    = ~fb_valid | fb_ready;
  assign accept      = out_free & ~stall & grant_valid;

  // Word-aligned, 28-bit frame-buffer address space: top nibble and byte offset are dropped
  assign addr_unused = ^{sel_beat.addr[ADDR_W-1:28], sel_beat.addr[1:0]};

  // One-hot ready to the owner; held low while reset is asserted
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = rst & accept & (grant == IDX_W'(i));
    end
  end

  // Next-state, pointer and burst counters
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    grant_id_d = grant_id;
    case (state_q)
      FBA_IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d    = FBA_LOCK;
            grant_id_d = grant;
            beat_cnt_d = BEAT_W'(1);
            idle_cnt_d = '0;
          end
        end
      end
      FBA_LOCK: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (sel_last || beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d    = FBA_IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (!sel_valid && !stall) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d    = FBA_IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      default: state_d = FBA_IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FBA_IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      grant_id   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      grant_id   <= grant_id_d;
    end
  end

  // Output stage: load on accept, drop valid once the memory side takes the beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_valid <= 1'b0;
      fb_q     <= '0;
    end else if (accept) begin
      fb_valid   <= 1'b1;
      fb_q.addr  <= {4'b0, sel_beat.addr[27:2], 2'b0};
      fb_q.din   <= sel_beat.din;
      fb_q.we    <= sel_beat.we;
    end else if (fb_ready) begin
      fb_valid   <= 1'b0;
      fb_q.we    <= '0;
    end
  end

  assign fb_addr = fb_q.addr;
  assign fb_din  = fb_q.din;
  assign fb_we   = fb_q.we;
  assign busy    = (state_q == FBA_LOCK);

endmodule
